// File: rtl/repair_remap_ctrl_pkg.sv
// Shared types and constants for the redundancy remap controller.
// Address layout is {bank select, word}; tags compare both fields.
package repair_remap_ctrl_pkg;

    localparam int NUM_ENTRIES_DEF = 32;
    localparam int ADDR_W_DEF      = 16;
    localparam int IDX_W_DEF       = 5;

    localparam int BANK_MSB = 15;
    localparam int BANK_LSB = 10;
    localparam int WORD_MSB = 9;
    localparam int WORD_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_COLLECT      = 2'd1,
        ST_ACTIVE       = 2'd2,
        ST_UNREPAIRABLE = 2'd3
    } state_e;

    function automatic logic addr_match(input logic [ADDR_W_DEF-1:0] a,
                                        input logic [ADDR_W_DEF-1:0] b);
        return (a[BANK_MSB:BANK_LSB] == b[BANK_MSB:BANK_LSB]) &&
               (a[WORD_MSB:WORD_LSB] == b[WORD_MSB:WORD_LSB]);
    endfunction

endpackage

// File: rtl/remap_cam.sv
// Valid+tag array with one write port, clear-all, and two independent
// compare ports that each report a hit and the lowest matching index.
module remap_cam
    import repair_remap_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_all,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_tag,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_hit,
    output logic [IDX_W-1:0]  a_idx,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_hit,
    output logic [IDX_W-1:0]  b_idx
);

    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    logic [ADDR_W-1:0]      tag_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] match_a;
    logic [NUM_ENTRIES-1:0] match_b;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
            assign match_a[gi] = valid_q[gi] && addr_match(tag_q[gi], a_addr);
            assign match_b[gi] = valid_q[gi] && addr_match(tag_q[gi], b_addr);
        end
    endgenerate

    // Clear wins over write so a new collection never inherits a stale entry.
    always_comb begin
        valid_d = valid_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    // Descending scan leaves the lowest matching index in place.
    always_comb begin
        a_hit = |match_a;
        a_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match_a[i]) begin
                a_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        b_hit = |match_b;
        b_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match_b[i]) begin
                b_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/repair_remap_ctrl.sv
// Collects BIST fault addresses into the remap CAM, decides repairability,
// and performs a one-cycle spare lookup for every host access.
module repair_remap_ctrl
    import repair_remap_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              BIST_EN,
    input  logic              BIST_DONE,
    input  logic              FAIL_VALID,
    input  logic [ADDR_W-1:0] FAIL_ADDR,
    input  logic              REQ_VALID,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    output logic              RSP_VALID,
    output logic              RSP_HIT,
    output logic [IDX_W-1:0]  RSP_IDX,
    output logic              REPAIR_EN,
    output logic              REPAIR_FAIL,
    output logic [IDX_W:0]    FAIL_COUNT
);

    state_e           state_q, state_d;
    logic             bist_en_q;
    logic             overflow_q, overflow_d;
    logic [IDX_W:0]   fail_count_q, fail_count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

    logic             bist_rise;
    logic             bist_fall;
    logic             table_full;
    logic             cam_clr;
    logic             cam_wr;
    logic             dd_hit;
    logic [IDX_W-1:0] dd_idx;
    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;

    assign bist_rise  = BIST_EN && !bist_en_q;
    assign bist_fall  = !BIST_EN && bist_en_q;
    assign table_full = (fail_count_q == (IDX_W+1)'(NUM_ENTRIES));

    remap_cam #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W)
    ) u_cam (
        .clk     (CLK),
        .rst_n   (RSTN),
        .clr_all (cam_clr),
        .wr_en   (cam_wr),
        .wr_idx  (fail_count_q[IDX_W-1:0]),
        .wr_tag  (FAIL_ADDR),
        .a_addr  (FAIL_ADDR),
        .a_hit   (dd_hit),
        .a_idx   (dd_idx),
        .b_addr  (REQ_ADDR),
        .b_hit   (lk_hit),
        .b_idx   (lk_idx)
    );

    always_comb begin
        state_d      = state_q;
        overflow_d   = overflow_q;
        fail_count_d = fail_count_q;
        cam_clr      = 1'b0;
        cam_wr       = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (FAIL_VALID && !dd_hit) begin
                    if (table_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        cam_wr       = 1'b1;
                        fail_count_d = fail_count_q + 1'b1;
                    end
                end
                // Decision uses the overflow flag after this cycle's fault.
                if (BIST_DONE || bist_fall) begin
                    state_d = overflow_d ? ST_UNREPAIRABLE : ST_ACTIVE;
                end
            end
            default: begin
                if (bist_rise) begin
                    state_d      = ST_COLLECT;
                    overflow_d   = 1'b0;
                    fail_count_d = '0;
                    cam_clr      = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        rsp_valid_d = REQ_VALID;
        rsp_hit_d   = 1'b0;
        rsp_idx_d   = '0;
        if (REQ_VALID && (state_q == ST_ACTIVE) && lk_hit) begin
            rsp_hit_d = 1'b1;
            rsp_idx_d = lk_idx;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            bist_en_q    <= 1'b0;
            overflow_q   <= 1'b0;
            fail_count_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            bist_en_q    <= BIST_EN;
            overflow_q   <= overflow_d;
            fail_count_q <= fail_count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_idx_q    <= rsp_idx_d;
        end
    end

    assign RSP_VALID   = rsp_valid_q;
    assign RSP_HIT     = rsp_hit_q;
    assign RSP_IDX     = rsp_idx_q;
    assign REPAIR_EN   = (state_q == ST_ACTIVE);
    assign REPAIR_FAIL = (state_q == ST_UNREPAIRABLE);
    assign FAIL_COUNT  = fail_count_q;

endmodule

// File: tb/tb_repair_remap_ctrl.sv
// Directed bench for repair_remap_ctrl: collection, dedupe, overflow,
// same-cycle done, re-collection and asynchronous reset.
module tb_repair_remap_ctrl;

    logic        CLK;
    logic        RSTN;
    logic        BIST_EN;
    logic        BIST_DONE;
    logic        FAIL_VALID;
    logic [15:0] FAIL_ADDR;
    logic        REQ_VALID;
    logic [15:0] REQ_ADDR;
    logic        RSP_VALID;
    logic        RSP_HIT;
    logic [4:0]  RSP_IDX;
    logic        REPAIR_EN;
    logic        REPAIR_FAIL;
    logic [5:0]  FAIL_COUNT;

    int checks_cnt;
    int fail_cnt;

    repair_remap_ctrl dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .BIST_EN     (BIST_EN),
        .BIST_DONE   (BIST_DONE),
        .FAIL_VALID  (FAIL_VALID),
        .FAIL_ADDR   (FAIL_ADDR),
        .REQ_VALID   (REQ_VALID),
        .REQ_ADDR    (REQ_ADDR),
        .RSP_VALID   (RSP_VALID),
        .RSP_HIT     (RSP_HIT),
        .RSP_IDX     (RSP_IDX),
        .REPAIR_EN   (REPAIR_EN),
        .REPAIR_FAIL (REPAIR_FAIL),
        .FAIL_COUNT  (FAIL_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fault(input logic [15:0] a);
        FAIL_VALID = 1'b1;
        FAIL_ADDR  = a;
        tick();
        FAIL_VALID = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] a);
        REQ_VALID = 1'b1;
        REQ_ADDR  = a;
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic done_pulse();
        BIST_DONE = 1'b1;
        tick();
        BIST_DONE = 1'b0;
    endtask

    task automatic restart_bist();
        BIST_EN = 1'b0;
        tick();
        BIST_EN = 1'b1;
        tick();
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        RSTN       = 1'b0;
        BIST_EN    = 1'b0;
        BIST_DONE  = 1'b0;
        FAIL_VALID = 1'b0;
        FAIL_ADDR  = '0;
        REQ_VALID  = 1'b0;
        REQ_ADDR   = '0;
        tick();
        tick();
        check("rst_rsp_valid", 32'(RSP_VALID), 0);
        check("rst_rsp_hit", 32'(RSP_HIT), 0);
        check("rst_rsp_idx", 32'(RSP_IDX), 0);
        check("rst_repair_en", 32'(REPAIR_EN), 0);
        check("rst_repair_fail", 32'(REPAIR_FAIL), 0);
        check("rst_fail_count", 32'(FAIL_COUNT), 0);
        RSTN = 1'b1;
        tick();

        lookup(16'h0400);
        check("idle_rsp_valid", 32'(RSP_VALID), 1);
        check("idle_rsp_hit", 32'(RSP_HIT), 0);
        check("idle_repair_en", 32'(REPAIR_EN), 0);
        tick();
        check("rsp_valid_drop", 32'(RSP_VALID), 0);

        // Basic collection with a duplicate fault.
        BIST_EN = 1'b1;
        tick();
        check("collect_count0", 32'(FAIL_COUNT), 0);
        fault(16'h0403);
        fault(16'h8001);
        fault(16'h0403);
        check("dedupe_count", 32'(FAIL_COUNT), 2);
        done_pulse();
        check("active_repair_en", 32'(REPAIR_EN), 1);
        check("active_count", 32'(FAIL_COUNT), 2);
        BIST_EN = 1'b0;
        lookup(16'h8001);
        check("hit_8001", 32'(RSP_HIT), 1);
        check("idx_8001", 32'(RSP_IDX), 1);
        lookup(16'h0403);
        check("hit_0403", 32'(RSP_HIT), 1);
        check("idx_0403", 32'(RSP_IDX), 0);
        lookup(16'h0404);
        check("miss_0404", 32'(RSP_HIT), 0);
        check("miss_idx", 32'(RSP_IDX), 0);
        fault(16'h5555);
        check("fail_ignored_active", 32'(FAIL_COUNT), 2);

        // Re-collection from ACTIVE; BIST_EN falling acts as done.
        BIST_EN = 1'b1;
        tick();
        check("recollect_count", 32'(FAIL_COUNT), 0);
        check("recollect_repair_en", 32'(REPAIR_EN), 0);
        fault(16'h1234);
        BIST_EN = 1'b0;
        tick();
        check("fall_done_repair_en", 32'(REPAIR_EN), 1);
        check("fall_done_count", 32'(FAIL_COUNT), 1);
        lookup(16'h8001);
        check("old_map_gone", 32'(RSP_HIT), 0);
        lookup(16'h1234);
        check("new_map_hit", 32'(RSP_HIT), 1);
        check("new_map_idx", 32'(RSP_IDX), 0);

        // Overflow: 33 distinct faults.
        restart_bist();
        for (int i = 0; i < 33; i++) begin
            fault(16'h2000 + 16'(i));
        end
        check("ovf_count_sat", 32'(FAIL_COUNT), 32);
        done_pulse();
        check("ovf_repair_fail", 32'(REPAIR_FAIL), 1);
        check("ovf_repair_en", 32'(REPAIR_EN), 0);
        check("ovf_count_hold", 32'(FAIL_COUNT), 32);
        lookup(16'h2000);
        check("ovf_lookup_hit", 32'(RSP_HIT), 0);
        check("ovf_lookup_idx", 32'(RSP_IDX), 0);

        // Last slot filled in the same cycle as BIST_DONE.
        restart_bist();
        check("unrep_to_collect", 32'(REPAIR_FAIL), 0);
        for (int i = 0; i < 31; i++) begin
            fault(16'h3000 + 16'(i));
        end
        check("pre_done_count", 32'(FAIL_COUNT), 31);
        FAIL_VALID = 1'b1;
        FAIL_ADDR  = 16'hFFFF;
        BIST_DONE  = 1'b1;
        tick();
        FAIL_VALID = 1'b0;
        BIST_DONE  = 1'b0;
        check("same_cycle_count", 32'(FAIL_COUNT), 32);
        check("same_cycle_repair_en", 32'(REPAIR_EN), 1);
        check("same_cycle_repair_fail", 32'(REPAIR_FAIL), 0);
        lookup(16'hFFFF);
        check("ffff_hit", 32'(RSP_HIT), 1);
        check("ffff_idx", 32'(RSP_IDX), 31);
        lookup(16'h301E);
        check("301e_idx", 32'(RSP_IDX), 30);

        // Asynchronous reset in the middle of a collection.
        restart_bist();
        for (int i = 0; i < 5; i++) begin
            fault(16'h4000 + 16'(i));
        end
        check("mid_collect_count", 32'(FAIL_COUNT), 5);
        REQ_VALID = 1'b1;
        REQ_ADDR  = 16'h4000;
        tick();
        REQ_VALID = 1'b0;
        check("pre_rst_rsp_valid", 32'(RSP_VALID), 1);
        BIST_EN = 1'b0;
        RSTN    = 1'b0;
        #1;
        check("async_rst_count", 32'(FAIL_COUNT), 0);
        check("async_rst_rsp_valid", 32'(RSP_VALID), 0);
        tick();
        RSTN = 1'b1;
        tick();
        done_pulse();
        check("post_rst_repair_en", 32'(REPAIR_EN), 0);
        check("post_rst_repair_fail", 32'(REPAIR_FAIL), 0);
        fault(16'h4001);
        check("post_rst_count", 32'(FAIL_COUNT), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
